// File: rtl/core_pkg.sv
// Core-wide constants shared by the rename/issue/execute/regfile blocks.
// Holds the physical register count, its index width and the index type.
package core_pkg;

    localparam int NUM_PREGS  = 64;
    localparam int PREG_IDX_W = $clog2(NUM_PREGS);

    typedef logic [PREG_IDX_W-1:0] preg_idx_t;

endpackage

// File: rtl/preg_file_if.sv
// Execute/regfile interface: writeback, rename allocation and issue reads.
// Modports: master (core side drives), slave / PhysRegFile (regfile side).
interface preg_file_if #(
    parameter int NUM_PREGS = core_pkg::NUM_PREGS,
    parameter int DATA_W    = 32
);
    localparam int IDX_W = $clog2(NUM_PREGS);

    logic              ex_valid;
    logic [DATA_W-1:0] ex_dst_val;
    logic [IDX_W-1:0]  ex_dst_index;
    logic              alloc_valid;
    logic [IDX_W-1:0]  alloc_index;
    logic [IDX_W-1:0]  rd_index_a;
    logic [IDX_W-1:0]  rd_index_b;
    logic [DATA_W-1:0] rd_val_a;
    logic [DATA_W-1:0] rd_val_b;
    logic              rd_rdy_a;
    logic              rd_rdy_b;

    modport master (
        output ex_valid, ex_dst_val, ex_dst_index,
        output alloc_valid, alloc_index,
        output rd_index_a, rd_index_b,
        input  rd_val_a, rd_val_b, rd_rdy_a, rd_rdy_b
    );

    modport slave (
        input  ex_valid, ex_dst_val, ex_dst_index,
        input  alloc_valid, alloc_index,
        input  rd_index_a, rd_index_b,
        output rd_val_a, rd_val_b, rd_rdy_a, rd_rdy_b
    );

    modport PhysRegFile (
        input  ex_valid, ex_dst_val, ex_dst_index,
        input  alloc_valid, alloc_index,
        input  rd_index_a, rd_index_b,
        output rd_val_a, rd_val_b, rd_rdy_a, rd_rdy_b
    );

endinterface

// File: rtl/preg_ready_table.sv
// Per-register ready bits: set on writeback, cleared on allocation (clear wins).
// Ports: clk, rst, set_en/set_index, clr_en/clr_index, two registered read ports.
// Option PREG_BYPASS_EN: a read colliding with a set returns the post-write bit.
module preg_ready_table
    import core_pkg::*;
#(
    parameter int NUM_PREGS = core_pkg::NUM_PREGS,
    localparam int IDX_W    = $clog2(NUM_PREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_en,
    input  logic [IDX_W-1:0] set_index,
    input  logic             clr_en,
    input  logic [IDX_W-1:0] clr_index,
    input  logic [IDX_W-1:0] rd_index_a,
    input  logic [IDX_W-1:0] rd_index_b,
    output logic             rd_rdy_a,
    output logic             rd_rdy_b
);

    logic [NUM_PREGS-1:0] rdy_q, rdy_d;
    logic                 rd_rdy_a_q, rd_rdy_a_d;
    logic                 rd_rdy_b_q, rd_rdy_b_d;

    function automatic logic rd_bit(input logic [IDX_W-1:0] idx);
        if (idx == '0) return 1'b1;
`ifdef PREG_BYPASS_EN
        // A same-cycle alloc still owns the bit, so bypass reports not-ready.
        if (set_en && idx == set_index)
            return !(clr_en && idx == clr_index);
`endif
        return rdy_q[idx];
    endfunction

    always_comb begin
        rdy_d = rdy_q;
        if (set_en) rdy_d[set_index] = 1'b1;
        if (clr_en) rdy_d[clr_index] = 1'b0;
        rd_rdy_a_d = rd_bit(rd_index_a);
        rd_rdy_b_d = rd_bit(rd_index_b);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_q      <= '1;
            rd_rdy_a_q <= 1'b1;
            rd_rdy_b_q <= 1'b1;
        end else begin
            rdy_q      <= rdy_d;
            rd_rdy_a_q <= rd_rdy_a_d;
            rd_rdy_b_q <= rd_rdy_b_d;
        end
    end

    assign rd_rdy_a = rd_rdy_a_q;
    assign rd_rdy_b = rd_rdy_b_q;

endmodule

// File: rtl/preg_file.sv
// Physical register file: data array, two synchronous read ports, ready bits.
// Ports: clk, rst (sync, active high), rf (preg_file_if.PhysRegFile).
// Option PREG_BYPASS_EN: reads colliding with a writeback return the new value.
module preg_file
    import core_pkg::*;
#(
    parameter int NUM_PREGS = core_pkg::NUM_PREGS,
    parameter int DATA_W    = 32,
    localparam int IDX_W    = $clog2(NUM_PREGS)
) (
    input  logic             clk,
    input  logic             rst,
    preg_file_if.PhysRegFile rf
);

    logic [DATA_W-1:0] mem_q [NUM_PREGS];
    logic [DATA_W-1:0] mem_d [NUM_PREGS];
    logic [DATA_W-1:0] rd_val_a_q, rd_val_a_d;
    logic [DATA_W-1:0] rd_val_b_q, rd_val_b_d;
    logic              wr_en;
    logic              al_en;

    // Register 0 is hardwired: never written, never allocated.
    assign wr_en = rf.ex_valid && (rf.ex_dst_index != '0);
    assign al_en = rf.alloc_valid && (rf.alloc_index != '0);

    function automatic logic [DATA_W-1:0] rd_data(
        input logic [IDX_W-1:0] idx
    );
        if (idx == '0) return '0;
`ifdef PREG_BYPASS_EN
        if (wr_en && idx == rf.ex_dst_index) return rf.ex_dst_val;
`endif
        return mem_q[idx];
    endfunction

    always_comb begin
        mem_d = mem_q;
        if (wr_en) mem_d[rf.ex_dst_index] = rf.ex_dst_val;
        rd_val_a_d = rd_data(rf.rd_index_a);
        rd_val_b_d = rd_data(rf.rd_index_b);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q      <= '{default: '0};
            rd_val_a_q <= '0;
            rd_val_b_q <= '0;
        end else begin
            mem_q      <= mem_d;
            rd_val_a_q <= rd_val_a_d;
            rd_val_b_q <= rd_val_b_d;
        end
    end

    preg_ready_table #(
        .NUM_PREGS (NUM_PREGS)
    ) u_ready (
        .clk        (clk),
        .rst        (rst),
        .set_en     (wr_en),
        .set_index  (rf.ex_dst_index),
        .clr_en     (al_en),
        .clr_index  (rf.alloc_index),
        .rd_index_a (rf.rd_index_a),
        .rd_index_b (rf.rd_index_b),
        .rd_rdy_a   (rf.rd_rdy_a),
        .rd_rdy_b   (rf.rd_rdy_b)
    );

    assign rf.rd_val_a = rd_val_a_q;
    assign rf.rd_val_b = rd_val_b_q;

endmodule

// File: tb/tb_preg_file.sv
// Directed self-checking bench for preg_file (both PREG_BYPASS_EN builds).
// Drives inputs #1 after the rising edge and samples outputs at the same point.
module tb_preg_file;
    import core_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    preg_file_if #(.NUM_PREGS(64), .DATA_W(32)) rf ();

    preg_file #(.NUM_PREGS(64), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .rf  (rf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rf.ex_valid     = 1'b0;
        rf.ex_dst_val   = '0;
        rf.ex_dst_index = '0;
        rf.alloc_valid  = 1'b0;
        rf.alloc_index  = '0;
    endtask

    task automatic write(input int idx, input logic [31:0] v);
        rf.ex_valid     = 1'b1;
        rf.ex_dst_index = 6'(idx);
        rf.ex_dst_val   = v;
        step();
        idle();
    endtask

    task automatic alloc(input int idx);
        rf.alloc_valid = 1'b1;
        rf.alloc_index = 6'(idx);
        step();
        idle();
    endtask

    task automatic test_reset();
        idle();
        rf.rd_index_a = 6'd5;
        rf.rd_index_b = 6'd6;
        rst = 1'b1;
        step();
        step();
        n_cmp++;
        if (rf.rd_val_b !== 32'h0 || rf.rd_rdy_b !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_out_b: got %h/%b want 0/1",
                     rf.rd_val_b, rf.rd_rdy_b);
        end
        rst = 1'b0;
        step();
        n_cmp++;
        if (rf.rd_val_a !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_val5: got %h want 0", rf.rd_val_a);
        end
        n_cmp++;
        if (rf.rd_rdy_a !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_rdy5: got %b want 1", rf.rd_rdy_a);
        end
    endtask

    task automatic test_alloc_write();
        alloc(7);
        rf.rd_index_a = 6'd7;
        step();
        n_cmp++;
        if (rf.rd_rdy_a !== 1'b0 || rf.rd_val_a !== 32'h0) begin
            n_bad++;
            $display("FAIL alloc7: got %h/%b want 0/0",
                     rf.rd_val_a, rf.rd_rdy_a);
        end
        rf.rd_index_a = 6'd0;
        write(7, 32'hDEADBEEF);
        rf.rd_index_a = 6'd7;
        step();
        n_cmp++;
        if (rf.rd_val_a !== 32'hDEADBEEF || rf.rd_rdy_a !== 1'b1) begin
            n_bad++;
            $display("FAIL write7: got %h/%b want deadbeef/1",
                     rf.rd_val_a, rf.rd_rdy_a);
        end
    endtask

    task automatic test_zero();
        rf.rd_index_a = 6'd0;
        rf.rd_index_b = 6'd0;
        for (int i = 0; i < 3; i++) begin
            rf.ex_valid     = 1'b1;
            rf.ex_dst_index = 6'd0;
            rf.ex_dst_val   = 32'h1234;
            rf.alloc_valid  = (i == 1);
            rf.alloc_index  = 6'd0;
            step();
            n_cmp++;
            if (rf.rd_val_a !== 32'h0 || rf.rd_rdy_a !== 1'b1 ||
                rf.rd_val_b !== 32'h0 || rf.rd_rdy_b !== 1'b1) begin
                n_bad++;
                $display("FAIL zero[%0d]: got a=%h/%b b=%h/%b want 0/1",
                         i, rf.rd_val_a, rf.rd_rdy_a,
                         rf.rd_val_b, rf.rd_rdy_b);
            end
        end
        idle();
    endtask

    task automatic test_collision();
        logic [31:0] ev;
        logic        er;
        write(9, 32'h11);
        alloc(9);
        rf.rd_index_a   = 6'd9;
        rf.ex_valid     = 1'b1;
        rf.ex_dst_index = 6'd9;
        rf.ex_dst_val   = 32'hA5A5A5A5;
        step();
        idle();
`ifdef PREG_BYPASS_EN
        ev = 32'hA5A5A5A5;
        er = 1'b1;
`else
        ev = 32'h11;
        er = 1'b0;
`endif
        n_cmp++;
        if (rf.rd_val_a !== ev || rf.rd_rdy_a !== er) begin
            n_bad++;
            $display("FAIL collide9: got %h/%b want %h/%b",
                     rf.rd_val_a, rf.rd_rdy_a, ev, er);
        end
        step();
        n_cmp++;
        if (rf.rd_val_a !== 32'hA5A5A5A5 || rf.rd_rdy_a !== 1'b1) begin
            n_bad++;
            $display("FAIL after9: got %h/%b want a5a5a5a5/1",
                     rf.rd_val_a, rf.rd_rdy_a);
        end
    endtask

    task automatic test_alloc_and_write();
        rf.alloc_valid = 1'b1;
        rf.alloc_index = 6'd12;
        write(12, 32'h55);
        rf.rd_index_a = 6'd12;
        rf.rd_index_b = 6'd12;
        step();
        n_cmp++;
        if (rf.rd_val_a !== 32'h55 || rf.rd_rdy_a !== 1'b0 ||
            rf.rd_val_b !== 32'h55 || rf.rd_rdy_b !== 1'b0) begin
            n_bad++;
            $display("FAIL both12: got a=%h/%b b=%h/%b want 55/0",
                     rf.rd_val_a, rf.rd_rdy_a, rf.rd_val_b, rf.rd_rdy_b);
        end
    endtask

    task automatic test_read_alloc();
        write(20, 32'h20);
        rf.rd_index_a = 6'd20;
        alloc(20);
        n_cmp++;
        if (rf.rd_rdy_a !== 1'b1 || rf.rd_val_a !== 32'h20) begin
            n_bad++;
            $display("FAIL ralloc20: got %h/%b want 20/1",
                     rf.rd_val_a, rf.rd_rdy_a);
        end
        step();
        n_cmp++;
        if (rf.rd_rdy_a !== 1'b0) begin
            n_bad++;
            $display("FAIL post20: got %b want 0", rf.rd_rdy_a);
        end
    endtask

    task automatic test_back_to_back();
        rf.rd_index_a = 6'd7;
        rf.rd_index_b = 6'd12;
        step();
        rf.rd_index_a = 6'd12;
        rf.rd_index_b = 6'd9;
        n_cmp++;
        if (rf.rd_val_a !== 32'hDEADBEEF || rf.rd_val_b !== 32'h55) begin
            n_bad++;
            $display("FAIL b2b0: got a=%h b=%h want deadbeef/55",
                     rf.rd_val_a, rf.rd_val_b);
        end
        step();
        n_cmp++;
        if (rf.rd_val_a !== 32'h55 || rf.rd_val_b !== 32'hA5A5A5A5 ||
            rf.rd_rdy_a !== 1'b0 || rf.rd_rdy_b !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b1: got a=%h/%b b=%h/%b want 55/0 a5a5a5a5/1",
                     rf.rd_val_a, rf.rd_rdy_a, rf.rd_val_b, rf.rd_rdy_b);
        end
    endtask

    task automatic test_reset_mid();
        write(3, 32'h77);
        rf.rd_index_a = 6'd3;
        rf.rd_index_b = 6'd3;
        step();
        n_cmp++;
        if (rf.rd_val_a !== 32'h77) begin
            n_bad++;
            $display("FAIL pre3: got %h want 77", rf.rd_val_a);
        end
        rst             = 1'b1;
        rf.ex_valid     = 1'b1;
        rf.ex_dst_index = 6'd4;
        rf.ex_dst_val   = 32'h44;
        rf.alloc_valid  = 1'b1;
        rf.alloc_index  = 6'd5;
        step();
        idle();
        rst = 1'b0;
        n_cmp++;
        if (rf.rd_val_a !== 32'h0 || rf.rd_rdy_a !== 1'b1) begin
            n_bad++;
            $display("FAIL rstpend: got %h/%b want 0/1",
                     rf.rd_val_a, rf.rd_rdy_a);
        end
        rf.rd_index_b = 6'd4;
        step();
        n_cmp++;
        if (rf.rd_val_a !== 32'h0 || rf.rd_rdy_a !== 1'b1) begin
            n_bad++;
            $display("FAIL rst3: got %h/%b want 0/1",
                     rf.rd_val_a, rf.rd_rdy_a);
        end
        n_cmp++;
        if (rf.rd_val_b !== 32'h0) begin
            n_bad++;
            $display("FAIL rstdrop4: got %h want 0", rf.rd_val_b);
        end
        rf.rd_index_a = 6'd5;
        step();
        n_cmp++;
        if (rf.rd_rdy_a !== 1'b1) begin
            n_bad++;
            $display("FAIL rstdrop5: got %b want 1", rf.rd_rdy_a);
        end
    endtask

    initial begin
        rst           = 1'b1;
        rf.rd_index_a = '0;
        rf.rd_index_b = '0;
        idle();
        test_reset();
        test_alloc_write();
        test_zero();
        test_collision();
        test_alloc_and_write();
        test_read_alloc();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/preg_file.md
PREG_FILE -- requirements
Module: preg_file

Interface
REQ-001 SHALL take parameter NUM_PREGS, default from CORE_PKG (64), meaning the number of physical registers.
REQ-002 SHALL take parameter DATA_W, default 32, meaning the register data width.
REQ-003 clk  input  1  core clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 ex_valid  input  1  Execute writeback valid.
REQ-006 ex_dst_val  input  DATA_W  writeback value.
REQ-007 ex_dst_index  input  PREG_IDX_W  writeback physical register index.
REQ-008 alloc_valid  input  1  Rename allocates a new destination.
REQ-009 alloc_index  input  PREG_IDX_W  index being allocated; its ready bit is cleared.
REQ-010 rd_index_a, rd_index_b  input  PREG_IDX_W each  Issue read addresses.
REQ-011 rd_val_a, rd_val_b  output  DATA_W each  registered read data.
REQ-012 rd_rdy_a, rd_rdy_b  output  1 each  registered ready bit of the addressed register.

Function
REQ-013 Array SHALL hold NUM_PREGS x DATA_W values plus one ready bit per entry.
REQ-014 Write: ex_valid=1 and ex_dst_index!=0 SHALL store ex_dst_val and set ready at the next edge.
REQ-015 Index 0 SHALL read value 0 and ready 1 in all cycles; writes and allocations to index 0 SHALL be ignored.
REQ-016 Allocation: alloc_valid=1 and alloc_index!=0 SHALL clear that ready bit at the next edge; the value is unchanged.
REQ-017 Same-cycle alloc and writeback to the same nonzero index SHALL store the value and leave ready=0 (alloc wins the ready bit).
REQ-018 Reads SHALL be synchronous with 1-cycle latency: rd_*_x in cycle N+1 reflects rd_index_x sampled in cycle N.
REQ-019 Both read ports SHALL be independent; identical indices on both ports SHALL return identical data.
REQ-020 Read/write collision (ex_valid=1 and rd_index==ex_dst_index!=0 in the same cycle) SHALL follow the bypass setting in REQ-025.
REQ-021 Read/alloc collision SHALL return the pre-alloc ready bit (ready clears only after the edge).
REQ-022 Out-of-range indices cannot occur when NUM_PREGS is a power of two; NUM_PREGS SHALL be a power of two.

Reset
REQ-023 While rst=1 at an edge: all values SHALL be 0, all ready bits 1, and rd_val_*=0, rd_rdy_*=1 from the next cycle; writes and allocs in the same cycle are dropped.
REQ-024 A reset asserted mid-stream SHALL discard any pending read result; the first post-reset read SHALL be sampled in the cycle rst falls.

Configuration
REQ-025 Macro PREG_BYPASS_EN: when defined, a colliding read (REQ-020) SHALL return ex_dst_val with ready=1 (subject to REQ-017); when undefined, it SHALL return the old value and old ready bit (read-before-write).

Structure
REQ-026 CORE_PKG SHALL hold NUM_PREGS, PREG_IDX_W = $clog2(NUM_PREGS), and typedef preg_idx_t.
REQ-027 Ready-bit tracking SHALL live in the sub-module preg_ready_table (set/clear/read logic); the data array stays in preg_file.
REQ-028 preg_file SHALL be drivable from the PhysRegFile modport of the Execute/regfile interface without adaptation.

Verification
REQ-029 Reset, then read index 5 on port A -> rd_val_a=0 and rd_rdy_a=1 one cycle later.
REQ-030 Alloc idx 7; next cycle read 7 -> rdy=0; then write 7=0xDEADBEEF; next cycle read 7 -> val=0xDEADBEEF, rdy=1.
REQ-031 Write idx 0=0x1234 while reading 0 on both ports -> val=0 and rdy=1 on both ports, every cycle.
REQ-032 Write idx 9=0xA5A5A5A5 while reading 9 in the same cycle -> with PREG_BYPASS_EN: 0xA5A5A5A5, rdy=1; without: the old value and old rdy.
REQ-033 Alloc and write idx 12=0x55 in the same cycle -> next-cycle read of 12 gives val=0x55, rdy=0.
REQ-034 Write idx 3=0x77, assert rst for one cycle, then read 3 -> val=0, rdy=1.
